// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-bank writeback stage.
// Imported by wb_rr_arb, reg_writeback and the bench.
package wb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] dr;
      logic [DATA_W_DEF-1:0] data;
   } wb_res_t;

   // Round-robin pick for two requesters.
   // On a conflict the source not granted most recently wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input wb_src_e last);
      logic [1:0] g;
      g = req;
      if (req == 2'b11) begin
         g = (last == SRC_MEM) ? 2'b01 : 2'b10;
      end
      return g;
   endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Two-way round-robin arbiter for the writeback stage: req[0] = ALU, req[1] = MEM.
// gnt is combinational from req; last_grant advances on a granted cycle when adv is high.
module wb_rr_arb
   import wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt,
   output logic       last_grant
);

   wb_src_e last_grant_reg;

   always_comb begin
      gnt = rr_pick(req, last_grant_reg);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_reg <= SRC_MEM;
      end else if (adv && (gnt != 2'b00)) begin
         last_grant_reg <= gnt[1] ? SRC_MEM : SRC_ALU;
      end
   end

   assign last_grant = last_grant_reg;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates ALU/load results onto the register-bank write port,
// counts commits and, with REG_WRITEBACK_BYPASS_EN defined, provides read-port bypass.
module reg_writeback
   import wb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int ZERO_DROP = 0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_dr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_dr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] dr,
   output logic [DATA_W-1:0] wrdata,
   output logic              write,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   output logic              byp1_hit,
   output logic [DATA_W-1:0] byp1_data,
   output logic              byp2_hit,
   output logic [DATA_W-1:0] byp2_data,
   output logic [15:0]       wb_cnt
);

   logic [1:0]        gnt;
   logic              arb_last_unused;
   logic              xfer;
   logic              drop;
   logic [ADDR_W-1:0] win_dr;
   logic [DATA_W-1:0] win_data;

   logic              write_reg;
   logic [ADDR_W-1:0] dr_reg;
   logic [DATA_W-1:0] wrdata_reg;
   logic [15:0]       wb_cnt_reg;

   // The register bank never stalls, so the arbiter may advance on every grant.
   wb_rr_arb u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        ({mem_valid, alu_valid}),
      .adv        (1'b1),
      .gnt        (gnt),
      .last_grant (arb_last_unused)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];

   always_comb begin
      xfer     = gnt[0] | gnt[1];
      win_dr   = gnt[1] ? mem_dr   : alu_dr;
      win_data = gnt[1] ? mem_data : alu_data;
      drop     = (ZERO_DROP != 0) && (win_dr == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_reg  <= 1'b0;
         dr_reg     <= '0;
         wrdata_reg <= '0;
         wb_cnt_reg <= '0;
      end else begin
         write_reg <= xfer && !drop;
         if (xfer) begin
            dr_reg     <= win_dr;
            wrdata_reg <= win_data;
         end
         if (write_reg) begin
            wb_cnt_reg <= wb_cnt_reg + 16'd1;
         end
      end
   end

   assign write  = write_reg;
   assign dr     = dr_reg;
   assign wrdata = wrdata_reg;
   assign wb_cnt = wb_cnt_reg;

   logic              byp_hit  [2];
   logic [DATA_W-1:0] byp_data [2];

`ifdef REG_WRITEBACK_BYPASS_EN
   logic [ADDR_W-1:0] sr_arr [2];
   assign sr_arr[0] = sr1;
   assign sr_arr[1] = sr2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_byp
      assign byp_hit[gi]  = write_reg && (sr_arr[gi] == dr_reg);
      assign byp_data[gi] = byp_hit[gi] ? wrdata_reg : '0;
   end
`else
   // Read addresses are only needed by the bypass comparators.
   logic sr_unused;
   assign sr_unused = ^{sr1, sr2};

   for (genvar gi = 0; gi < 2; gi++) begin : g_byp
      assign byp_hit[gi]  = 1'b0;
      assign byp_data[gi] = '0;
   end
`endif

   assign byp1_hit  = byp_hit[0];
   assign byp1_data = byp_data[0];
   assign byp2_hit  = byp_hit[1];
   assign byp2_data = byp_data[1];

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, with a queue scoreboard
// fed by a rule-level model. Honours REG_WRITEBACK_BYPASS_EN like the design.
module tb_reg_writeback;
   import wb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int ZD = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid, alu_ready, mem_valid, mem_ready;
   logic [AW-1:0] alu_dr, mem_dr, dr, sr1, sr2;
   logic [DW-1:0] alu_data, mem_data, wrdata, byp1_data, byp2_data;
   logic          write, byp1_hit, byp2_hit;
   logic [15:0]   wb_cnt;

   always #5 clk = ~clk;

   reg_writeback #(.DATA_W(DW), .ADDR_W(AW), .ZERO_DROP(ZD)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dr(alu_dr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dr(mem_dr), .mem_data(mem_data),
      .dr(dr), .wrdata(wrdata), .write(write),
      .sr1(sr1), .sr2(sr2),
      .byp1_hit(byp1_hit), .byp1_data(byp1_data),
      .byp2_hit(byp2_hit), .byp2_data(byp2_data),
      .wb_cnt(wb_cnt)
   );

   typedef struct {
      bit          wr;
      logic [4:0]  dr;
      logic [31:0] data;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Model state: who was granted last (1 = ALU, 2 = MEM) and the current output view.
   int          m_last = 2;
   bit          m_wr   = 0;
   logic [4:0]  m_dr   = '0;
   logic [31:0] m_data = '0;
   logic [15:0] m_cnt  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Evaluate one cycle of the rules for the currently driven inputs; returns 0/1/2 = none/ALU/MEM.
   task automatic model_step(output int g);
      exp_t e;
      g = 0;
      if (alu_valid && mem_valid) g = (m_last == 2) ? 1 : 2;
      else if (alu_valid)         g = 1;
      else if (mem_valid)         g = 2;
      check("alu_ready", 32'(alu_ready), 32'(g == 1));
      check("mem_ready", 32'(mem_ready), 32'(g == 2));
      if (!rst_n) begin
         m_last = 2; m_wr = 0; m_dr = '0; m_data = '0; m_cnt = '0;
      end else begin
         if (m_wr) m_cnt = m_cnt + 16'd1;
         m_wr = 0;
         if (g != 0) begin
            m_last = g;
            m_dr   = (g == 1) ? alu_dr   : mem_dr;
            m_data = (g == 1) ? alu_data : mem_data;
            m_wr   = !(ZD != 0 && m_dr == 0);
         end
      end
      e.wr = m_wr; e.dr = m_dr; e.data = m_data; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit rn, input bit av, input wb_res_t ar, input bit mv, input wb_res_t mr,
                        input logic [4:0] s1, input logic [4:0] s2, output int g);
      @(negedge clk);
      rst_n = rn;
      alu_valid = av; alu_dr = ar.dr; alu_data = ar.data;
      mem_valid = mv; mem_dr = mr.dr; mem_data = mr.data;
      sr1 = s1; sr2 = s2;
      #1;
      model_step(g);
   endtask

   // Monitor: one expected entry per clock edge, compared just after the edge.
   initial begin
      exp_t e;
      bit   h1, h2;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write",  32'(write),  32'(e.wr));
            check("dr",     32'(dr),     32'(e.dr));
            check("wrdata", wrdata,      e.data);
            check("wb_cnt", 32'(wb_cnt), 32'(e.cnt));
`ifdef REG_WRITEBACK_BYPASS_EN
            h1 = e.wr && (sr1 == e.dr);
            h2 = e.wr && (sr2 == e.dr);
`else
            h1 = 0;
            h2 = 0;
`endif
            check("byp1_hit",  32'(byp1_hit), 32'(h1));
            check("byp1_data", byp1_data,     h1 ? e.data : 32'h0);
            check("byp2_hit",  32'(byp2_hit), 32'(h2));
            check("byp2_data", byp2_data,     h2 ? e.data : 32'h0);
            if (write)
               $display("wb t=%0t dr=%0d data=%h cnt=%0d", $time, dr, wrdata, wb_cnt);
         end
      end
   end

   initial begin
      int      g;
      wb_res_t a, m, idle;
      bit      av, mv, a_acc, m_acc;
      idle = '0;
      rst_n = 1'b0; alu_valid = 0; mem_valid = 0;
      alu_dr = '0; alu_data = '0; mem_dr = '0; mem_data = '0; sr1 = '0; sr2 = '0;

      // Reset with both sources valid; ALU must be first to win afterwards.
      a = '{dr: 5'd2, data: 32'h0000_0A1A};
      m = '{dr: 5'd4, data: 32'h0000_0B1B};
      repeat (3) drive(0, 1, a, 1, m, 5'd2, 5'd4, g);
      drive(1, 1, a, 1, m, 5'd2, 5'd4, g);
      drive(1, 0, idle, 1, m, 5'd4, 5'd2, g);
      drive(1, 0, idle, 0, idle, 5'd0, 5'd0, g);

      // Alternating conflict: ALU r3 0x11.., MEM r7 0xA1..
      a = '{dr: 5'd3, data: 32'h11};
      m = '{dr: 5'd7, data: 32'hA1};
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, a, 1, m, 5'd3, 5'd7, g);
         if (g == 1) a.data = a.data + 1;
         if (g == 2) m.data = m.data + 1;
      end
      drive(1, 0, idle, 0, idle, 5'd3, 5'd7, g);

      // Bypass of a fresh ALU result.
      a = '{dr: 5'd5, data: 32'hDEAD_BEEF};
      drive(1, 1, a, 0, idle, 5'd5, 5'd6, g);
      drive(1, 0, idle, 0, idle, 5'd5, 5'd6, g);

      // Dropped r0 result from MEM.
      m = '{dr: 5'd0, data: 32'h55};
      drive(1, 0, idle, 1, m, 5'd0, 5'd0, g);
      drive(1, 0, idle, 0, idle, 5'd0, 5'd0, g);

      // Same destination r9 after an ALU grant: MEM first, then ALU.
      drive(1, 1, '{dr: 5'd1, data: 32'h1}, 0, idle, 5'd1, 5'd9, g);
      a = '{dr: 5'd9, data: 32'hA9A9_A9A9};
      m = '{dr: 5'd9, data: 32'hB9B9_B9B9};
      drive(1, 1, a, 1, m, 5'd9, 5'd9, g);
      drive(1, 1, a, 0, idle, 5'd9, 5'd9, g);
      drive(1, 0, idle, 0, idle, 5'd9, 5'd9, g);

      // Random traffic; producers hold a result until it is accepted.
      av = 0; mv = 0; a_acc = 0; m_acc = 0;
      for (int i = 0; i < 300; i++) begin
         if (!av || a_acc) begin
            av = ($urandom_range(0, 3) != 0);
            a.dr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            a.data = $urandom;
         end
         if (!mv || m_acc) begin
            mv = ($urandom_range(0, 3) != 0);
            m.dr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            m.data = $urandom;
         end
         drive(1, av, a, mv, m,
               $urandom_range(0, 1) ? a.dr : 5'($urandom_range(0, 31)),
               $urandom_range(0, 1) ? m.dr : 5'($urandom_range(0, 31)), g);
         a_acc = (g == 1);
         m_acc = (g == 2);
      end

      // Reset in the cycle after a handshake flushes the pending write.
      drive(1, 1, '{dr: 5'd12, data: 32'hC0DE}, 0, idle, 5'd12, 5'd0, g);
      drive(0, 0, idle, 0, idle, 5'd12, 5'd0, g);
      drive(1, 0, idle, 0, idle, 5'd12, 5'd0, g);
      drive(1, 0, idle, 0, idle, 5'd0, 5'd0, g);

      repeat (2) @(posedge clk);
      #2;
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
